spi_rr_scheduler: RTL and testbench

- Shares one SPI serial engine between NUM_REQ requesters, with a separate active-low chip select per requester.
- Arbitrates pending requests round-robin, latches the winner's parallel word and shifts it out on sclk/mosi (mode 0, MSB first).
- Pulses done back to the winner when its transfer finishes.
- Sits between the system-side producers and the SPI slave devices.

---
 rtl/spi_rr_scheduler.sv | 158 +++++++++++++++
 tb/tb_spi_rr_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rr_scheduler.sv
// spi_rr_scheduler: round-robin arbiter sharing one mode-0 SPI shifter across NUM_REQ chip selects.
// Define SPI_LSB_FIRST_EN to shift LSB first instead of MSB first.
module spi_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    output logic                      sclk,
    output logic                      mosi,
    output logic [NUM_REQ-1:0]        cs_n
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(DATA_W);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST_REQ = PW'(NUM_REQ - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [DW-1:0] LAST_DIV = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD} state_t;

    state_t              state, state_n;
    logic [PW-1:0]       ptr, ptr_n, own, own_n, win;
    logic [BW-1:0]       cnt, cnt_n;
    logic [DW-1:0]       div, div_n;
    logic [DATA_W-1:0]   sh, sh_n;
    logic [NUM_REQ-1:0]  grant_n, done_n, cs_n_n;
    logic                busy_n, sclk_n, mosi_n, found, last_div;

`ifdef SPI_LSB_FIRST_EN
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return w[0];
    endfunction
    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return {1'b0, w[DATA_W-1:1]};
    endfunction
`else
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return w[DATA_W-1];
    endfunction
    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return {w[DATA_W-2:0], 1'b0};
    endfunction
`endif

    // first pending requester at or after the pointer, wrapping
    always_comb begin
        win = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[(int'(ptr) + i) % NUM_REQ]) begin
                found = 1'b1;
                win = PW'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

    assign last_div = div == LAST_DIV;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        own_n   = own;
        cnt_n   = cnt;
        div_n   = div;
        sh_n    = sh;
        grant_n = '0;
        done_n  = '0;
        busy_n  = busy;
        sclk_n  = sclk;
        mosi_n  = mosi;
        cs_n_n  = cs_n;
        case (state)
            IDLE: if (found) begin
                state_n      = SHIFT_LO;
                own_n        = win;
                ptr_n        = win == LAST_REQ ? '0 : win + 1'b1;
                grant_n[win] = 1'b1;
                cs_n_n       = '1;
                cs_n_n[win]  = 1'b0;
                busy_n       = 1'b1;
                sh_n         = req_data[win*DATA_W +: DATA_W];
                mosi_n       = first_bit(sh_n);
                sclk_n       = 1'b0;
                div_n        = '0;
                cnt_n        = '0;
            end
            SHIFT_LO: begin
                div_n = last_div ? '0 : div + 1'b1;
                if (last_div) begin
                    sclk_n  = 1'b1;
                    state_n = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                div_n = last_div ? '0 : div + 1'b1;
                if (last_div) begin
                    sclk_n = 1'b0;
                    cnt_n  = cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        mosi_n  = 1'b0;
                        state_n = HOLD;
                    end else begin
                        sh_n    = advance(sh);
                        mosi_n  = first_bit(sh_n);
                        state_n = SHIFT_LO;
                    end
                end
            end
            HOLD: begin
                div_n = last_div ? '0 : div + 1'b1;
                if (last_div) begin
                    cs_n_n      = '1;
                    done_n[own] = 1'b1;
                    busy_n      = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            own   <= '0;
            cnt   <= '0;
            div   <= '0;
            sh    <= '0;
            grant <= '0;
            done  <= '0;
            busy  <= 1'b0;
            sclk  <= 1'b0;
            mosi  <= 1'b0;
            cs_n  <= '1;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            own   <= own_n;
            cnt   <= cnt_n;
            div   <= div_n;
            sh    <= sh_n;
            grant <= grant_n;
            done  <= done_n;
            busy  <= busy_n;
            sclk  <= sclk_n;
            mosi  <= mosi_n;
            cs_n  <= cs_n_n;
        end
    end
endmodule

// File: tb/tb_spi_rr_scheduler.sv
// tb_spi_rr_scheduler: transfer-timeline reference model plus directed tables for spi_rr_scheduler.
module tb_spi_rr_scheduler;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CD = 2;
    localparam int T  = 2 * CD * DW + CD;

    typedef struct {
        logic [N-1:0]    req;
        logic [N*DW-1:0] data;
        int              exp_w;
        logic [DW-1:0]   exp_word;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0;
    logic [N-1:0] req = '0, grant, done, cs_n;
    logic [N*DW-1:0] req_data = '0;
    logic busy, sclk, mosi;
    logic [N-1:0] req1 = '0, grant1, done1, cs_n1;
    logic [N*DW-1:0] data1 = '0;
    logic busy1, sclk1, mosi1;

    int n_cmp = 0, n_bad = 0;
    bit m_active = 0;
    int m_t = 0, m_w = 0, m_ptr = 0;
    logic [DW-1:0] m_word = '0;
    logic [N-1:0] cs_seen = '0;

    always #5 clk = ~clk;

    spi_rr_scheduler dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant), .done(done),
        .busy(busy), .sclk(sclk), .mosi(mosi), .cs_n(cs_n)
    );

    spi_rr_scheduler #(.NUM_REQ(N), .DATA_W(DW), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .req_data(data1), .grant(grant1), .done(done1),
        .busy(busy1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1)
    );

    // word rearranged into wire order, first transmitted bit in the MSB position
    function automatic logic [DW-1:0] ser(input logic [DW-1:0] w);
`ifdef SPI_LSB_FIRST_EN
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
        return r;
`else
        return w;
`endif
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int i = 0; i < N; i++) if (v[(start + i) % N]) return (start + i) % N;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // one clock: sample inputs at the edge, advance the model, compare after the edge
    task automatic tick();
        logic [N-1:0] rq, eg, ed, ec;
        logic [N*DW-1:0] dt;
        logic [DW-1:0] sw;
        logic r, es, em;
        int b;
        @(posedge clk);
        rq = req;
        dt = req_data;
        r  = rst;
        @(negedge clk);
        eg = '0;
        ed = '0;
        if (r) begin
            m_active = 0;
            m_ptr = 0;
        end else if (m_active) begin
            m_t++;
            if (m_t == T) begin
                m_active = 0;
                ed[m_w] = 1'b1;
            end
        end else if (rq != 0) begin
            m_w = pick(rq, m_ptr);
            m_ptr = (m_w + 1) % N;
            m_word = dt[m_w*DW +: DW];
            m_active = 1;
            m_t = 0;
            eg[m_w] = 1'b1;
        end
        ec = '1;
        if (m_active) ec[m_w] = 1'b0;
        es = m_active && m_t < 2 * CD * DW && (m_t / CD) % 2 == 1;
        b = m_t / (2 * CD);
        sw = ser(m_word);
        em = m_active && b < DW ? sw[DW-1-(b % DW)] : 1'b0;
        chk("cycle", {grant, done, busy, sclk, mosi, cs_n}, {eg, ed, m_active, es, em, ec});
        chk("cs_onehot", 32'($onehot0(~cs_n)), 1);
        cs_seen |= ~cs_n;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        #1;
        chk("async_reset", {grant, done, busy, sclk, mosi, cs_n}, 15'h000F);
        m_active = 0;
        m_ptr = 0;
        tick();
        tick();
        rst = 1'b0;
        cs_seen = '0;
    endtask

    task automatic capture(input bit hold, input int late_at, input logic [N*DW-1:0] late_data,
                           input int stop_rises, output int w, output logic [DW-1:0] word,
                           output int cs_low, output int rises, output int busy_cnt, output int dn);
        logic ps;
        int since;
        w = -1; word = '0; cs_low = 0; rises = 0; busy_cnt = 0; dn = -1; ps = sclk; since = 0;
        for (int i = 0; i < 200 && dn < 0 && !(stop_rises > 0 && rises == stop_rises); i++) begin
            tick();
            if (w >= 0) since++;
            if (grant != 0 && w < 0) begin
                w = pick(grant, 0);
                if (!hold) req &= ~grant;
            end
            if (w >= 0 && since == late_at) req_data = late_data;
            if (w >= 0 && cs_n != '1) cs_low++;
            if (busy) busy_cnt++;
            if (sclk && !ps) begin
                word = {word[DW-2:0], mosi};
                rises++;
            end
            ps = sclk;
            if (done != 0) dn = pick(done, 0);
        end
        if (dn < 0 && stop_rises == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL capture_timeout: got no done, required done within 200 cycles");
        end
    endtask

    initial begin
        vec_t tbl[6];
        int w, cl, rs, bc, dn, cl1, rs1, dn1;
        logic [DW-1:0] wd, wd1;
        logic ps1;
        tbl[0] = '{4'b0001, 32'h443322A5, 0, 8'hA5};
        tbl[1] = '{4'b0100, 32'h103C2050, 2, 8'h3C};
        tbl[2] = '{4'b1010, 32'hC3009600, 1, 8'h96};
        tbl[3] = '{4'b1000, 32'h01FFFFFF, 3, 8'h01};
        tbl[4] = '{4'b1111, 32'h8040207E, 0, 8'h7E};
        tbl[5] = '{4'b0110, 32'h0011FF00, 1, 8'hFF};
        @(negedge clk);
        foreach (tbl[i]) begin
            do_reset();
            req = tbl[i].req;
            req_data = tbl[i].data;
            capture(0, -1, '0, 0, w, wd, cl, rs, bc, dn);
            chk($sformatf("tbl%0d_winner", i), w, tbl[i].exp_w);
            chk($sformatf("tbl%0d_word", i), wd, ser(tbl[i].exp_word));
            chk($sformatf("tbl%0d_cs_low", i), cl, T);
            chk($sformatf("tbl%0d_rises", i), rs, DW);
            chk($sformatf("tbl%0d_busy", i), bc, T);
            chk($sformatf("tbl%0d_done", i), dn, tbl[i].exp_w);
        end

        do_reset();
        req = '1;
        req_data = 32'h44332211;
        for (int k = 0; k < N; k++) begin
            capture(0, -1, '0, 0, w, wd, cl, rs, bc, dn);
            chk("all_winner", w, k);
            chk("all_word", wd, ser(DW'(8'h11 * (k + 1))));
            chk("all_done", dn, k);
        end

        do_reset();
        req = 4'b0101;
        req_data = $urandom;
        for (int k = 0; k < 6; k++) begin
            capture(1, -1, '0, 0, w, wd, cl, rs, bc, dn);
            chk("fair_winner", w, (k % 2) * 2);
        end
        chk("fair_starved_cs", cs_seen & 4'b1010, 0);
        req = '0;

        do_reset();
        req = 4'b0010;
        req_data = 32'h00003C00;
        capture(0, 1, 32'h0000FF00, 0, w, wd, cl, rs, bc, dn);
        chk("stable_winner", w, 1);
        chk("stable_word", wd, ser(8'h3C));

        do_reset();
        req = 4'b0100;
        req_data = 32'h005A0000;
        capture(0, -1, '0, 3, w, wd, cl, rs, bc, dn);
        chk("midrst_rises", rs, 3);
        do_reset();
        req = 4'b0010;
        req_data = 32'h0000C300;
        capture(0, -1, '0, 0, w, wd, cl, rs, bc, dn);
        chk("midrst_winner", w, 1);
        chk("midrst_word", wd, ser(8'hC3));
        chk("midrst_cs_low", cl, T);

        do_reset();
        req1 = 4'b1000;
        data1 = 32'h01000000;
        cl1 = 0; rs1 = 0; dn1 = -1; ps1 = 1'b0; wd1 = '0;
        for (int i = 0; i < 100 && dn1 < 0; i++) begin
            tick();
            if (grant1 != 0) req1 = '0;
            if (!cs_n1[3]) cl1++;
            if (sclk1 && !ps1) begin
                wd1 = {wd1[DW-2:0], mosi1};
                rs1++;
            end
            ps1 = sclk1;
            if (done1 != 0) dn1 = pick(done1, 0);
        end
        chk("div1_cs_low", cl1, 2 * DW + 1);
        chk("div1_word", wd1, ser(8'h01));
        chk("div1_rises", rs1, DW);
        chk("div1_done", dn1, 3);

        do_reset();
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(3) == 0) req = N'($urandom);
            req_data = $urandom;
            if ($urandom_range(599) == 0) do_reset();
            else tick();
        end
        req = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
